gpu_cmd_sequencer: RTL

Parametrised successor to the GPU microcode control unit. It queues CPU commands in a FIFO and replays them back-to-back. It sequences the micro-address, repeat counter, N_PC program counters and an N_HALT-source conditional stall. An external opcode/microcode ROM decodes (op_out, uaddr) into the ucode_* control fields consumed here; datapath strobes elsewhere must be gated with ~stall.

---
 rtl/gpu_cmd_sequencer.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_sequencer.sv
// gpu_cmd_sequencer
// Queues CPU commands in a small FIFO and replays them back-to-back through a
// micro-address sequencer. Each command carries an opcode, a repeat count,
// N_PC program-counter start values and increments, and one immediate data
// word. An external ROM decodes (op_out, uaddr) into the ucode_* fields that
// steer this block. Datapath strobes elsewhere must be gated with ~stall.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   abort             synchronous flush of the queue and the current command
//   cmd_*             command push interface (valid/ready handshake)
//   op_out, uaddr     current instruction register and micro-address (ROM address)
//   ucode_seq         00 NEXT, 01 END, 10 REPEAT, 11 CONTINUE_OR_END
//   ucode_halt_sel    halt sources this micro-step waits on
//   ucode_pc_inc      per-PC increment enables for this micro-step
//   halt_src          busy flags from the rest of the GPU
//   stall             current micro-step is blocked by a selected busy source
//   pc_value          packed program counters, PC i at [i*PC_W +: PC_W]
//   data_out          immediate data of the current command
//   rep_left          remaining repeats of the current command
//   fifo_level        number of queued commands
//   busy              a command is running or queued
//   uaddr_err         sticky micro-address overflow flag
module gpu_cmd_sequencer #(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 13,
    parameter int INC_W      = 8,
    parameter int REP_W      = 8,
    parameter int OP_W       = 5,
    parameter int UADDR_W    = 6,
    parameter int N_PC       = 2,
    parameter int N_HALT     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          abort,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [OP_W-1:0]               cmd_opcode,
    input  logic [REP_W-1:0]              cmd_repeat,
    input  logic [N_PC*PC_W-1:0]          cmd_pc_start,
    input  logic [N_PC*INC_W-1:0]         cmd_pc_inc,
    input  logic [DATA_W-1:0]             cmd_data,
    output logic [OP_W-1:0]               op_out,
    output logic [UADDR_W-1:0]            uaddr,
    input  logic [1:0]                    ucode_seq,
    input  logic [N_HALT-1:0]             ucode_halt_sel,
    input  logic [N_PC-1:0]               ucode_pc_inc,
    input  logic [N_HALT-1:0]             halt_src,
    output logic                          stall,
    output logic [N_PC*PC_W-1:0]          pc_value,
    output logic [DATA_W-1:0]             data_out,
    output logic [REP_W-1:0]              rep_left,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          uaddr_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] SEQ_NEXT   = 2'b00;
    localparam logic [1:0] SEQ_END    = 2'b01;
    localparam logic [1:0] SEQ_REPEAT = 2'b10;
    localparam logic [1:0] SEQ_CONT   = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    // Command queue storage, one array per command field.
    logic [OP_W-1:0]       q_op    [FIFO_DEPTH];
    logic [REP_W-1:0]      q_rep   [FIFO_DEPTH];
    logic [N_PC*PC_W-1:0]  q_pc    [FIFO_DEPTH];
    logic [N_PC*INC_W-1:0] q_inc   [FIFO_DEPTH];
    logic [DATA_W-1:0]     q_data  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             fifo_empty, fifo_full;
    logic             push, pop;

    logic [N_PC*PC_W-1:0]  pc_q, pc_next;
    logic [N_PC*INC_W-1:0] inc_q;

    logic                  load, go_idle, advance, set_err, finish;
    logic                  uaddr_max;
    logic [UADDR_W-1:0]    uaddr_next;
    logic [REP_W-1:0]      rep_next;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign cmd_ready  = ~fifo_full & ~abort;
    assign push       = cmd_valid & cmd_ready;
    assign pop        = load;
    assign fifo_level = level;

    assign stall     = (state == S_RUN) & (|(halt_src & ucode_halt_sel));
    assign busy      = (state == S_RUN) | ~fifo_empty;
    assign pc_value  = pc_q;
    assign uaddr_max = &uaddr;

    // Next-state and micro-sequencing decisions. An overflow is only raised
    // where the sequencer would actually increment past the last micro-address;
    // REPEAT with repeats left jumps back to 0 and cannot overflow. Abort is
    // applied last so it overrides every other decision.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        go_idle    = 1'b0;
        advance    = 1'b0;
        set_err    = 1'b0;
        finish     = 1'b0;
        uaddr_next = uaddr;
        rep_next   = rep_left;

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    advance = 1'b1;
                    case (ucode_seq)
                        SEQ_NEXT: begin
                            if (uaddr_max) begin
                                finish  = 1'b1;
                                set_err = 1'b1;
                            end else begin
                                uaddr_next = uaddr + 1'b1;
                            end
                        end
                        SEQ_REPEAT: begin
                            if (rep_left != '0) begin
                                rep_next   = rep_left - 1'b1;
                                uaddr_next = '0;
                            end else if (uaddr_max) begin
                                finish  = 1'b1;
                                set_err = 1'b1;
                            end else begin
                                uaddr_next = uaddr + 1'b1;
                            end
                        end
                        SEQ_CONT: begin
                            if (rep_left == '0) begin
                                finish = 1'b1;
                            end else if (uaddr_max) begin
                                finish  = 1'b1;
                                set_err = 1'b1;
                            end else begin
                                uaddr_next = uaddr + 1'b1;
                            end
                        end
                        SEQ_END: begin
                            finish = 1'b1;
                        end
                        default: begin
                            finish = 1'b1;
                        end
                    endcase

                    // Zero-bubble hand-over: a queued command loads on the
                    // same edge that ends the current one.
                    if (finish) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            go_idle    = 1'b1;
                            uaddr_next = '0;
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (load) begin
            state_next = S_RUN;
        end else if (go_idle) begin
            state_next = S_IDLE;
        end

        if (abort) begin
            state_next = S_IDLE;
            load       = 1'b0;
            go_idle    = 1'b0;
            advance    = 1'b0;
            set_err    = 1'b0;
        end
    end

    // Modulo PC advance; increments are zero-extended to the PC width.
    always_comb begin
        pc_next = pc_q;
        for (int i = 0; i < N_PC; i++) begin
            if (advance && ucode_pc_inc[i]) begin
                pc_next[i*PC_W +: PC_W] = pc_q[i*PC_W +: PC_W]
                                        + PC_W'(inc_q[i*INC_W +: INC_W]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Queue pointers and level; abort empties the queue in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Queue storage has no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]   <= cmd_opcode;
            q_rep[wr_ptr]  <= cmd_repeat;
            q_pc[wr_ptr]   <= cmd_pc_start;
            q_inc[wr_ptr]  <= cmd_pc_inc;
            q_data[wr_ptr] <= cmd_data;
        end
    end

    // Command registers. Abort only clears the instruction/micro-address and
    // leaves PCs, data and repeat count where they were.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_out   <= '0;
            uaddr    <= '0;
            rep_left <= '0;
            pc_q     <= '0;
            inc_q    <= '0;
            data_out <= '0;
        end else if (abort) begin
            op_out <= '0;
            uaddr  <= '0;
        end else if (load) begin
            op_out   <= q_op[rd_ptr];
            rep_left <= q_rep[rd_ptr];
            pc_q     <= q_pc[rd_ptr];
            inc_q    <= q_inc[rd_ptr];
            data_out <= q_data[rd_ptr];
            uaddr    <= '0;
        end else if (advance) begin
            pc_q     <= pc_next;
            uaddr    <= uaddr_next;
            rep_left <= rep_next;
            if (go_idle) begin
                op_out <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uaddr_err <= 1'b0;
        end else if (abort) begin
            uaddr_err <= 1'b0;
        end else if (set_err) begin
            uaddr_err <= 1'b1;
        end
    end

endmodule
